// File: rtl/white_pixel_counter.sv
// white_pixel_counter
// Binarizes a framed pixel stream against a per-frame threshold and counts
// white pixels and total pixels. At end of frame it holds both counts on a
// valid/ready result port until the downstream comparator takes them.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   s_valid       input beat valid
//   s_ready       block can accept a beat (0 while holding a result or in reset)
//   s_pixel       smoothed pixel value
//   s_sof         beat is the first pixel of a frame
//   s_eof         beat is the last pixel of a frame
//   bin_threshold binarization threshold, latched on an accepted SOF beat
//   m_valid       frame result available
//   m_ready       downstream accepts result
//   m_count       white-pixel count of the last completed frame
//   m_total       total pixel count of the last completed frame
//   m_sat         either counter saturated during that frame
//   frame_err     one-cycle pulse after a framing violation
module white_pixel_counter #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_sof,
  input  logic             s_eof,
  input  logic [PIX_W-1:0] bin_threshold,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_count,
  output logic [CNT_W-1:0] m_total,
  output logic             m_sat,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: the counter sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic            inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [PIX_W-1:0] thr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] tot_r;
  logic             sat_r;
  logic             m_valid_r;
  logic [CNT_W-1:0] m_count_r;
  logic [CNT_W-1:0] m_total_r;
  logic             m_sat_r;
  logic             frame_err_r;

  logic             accept_s;
  logic             start_s;      // accepted SOF beat: begin a new frame
  logic             start_eof_s;  // SOF beat that is also EOF (single-pixel frame)
  logic             step_s;       // accepted in-frame beat without SOF
  logic             finish_s;     // in-frame beat carrying EOF
  logic             release_s;    // result handshake
  logic             err_s;
  logic             white_new_s;
  logic             white_acc_s;
  logic [CNT_W-1:0] cnt_sum_s;
  logic [CNT_W-1:0] tot_sum_s;
  logic             sat_sum_s;

  // Reset forces s_ready low so no beat can slip in during reset.
  assign s_ready  = rst_n && (state_r != HOLD);
  assign accept_s = s_valid && s_ready;

  // SOF beats compare against the incoming threshold, later beats against the latched one.
  assign white_new_s = (s_pixel > bin_threshold);
  assign white_acc_s = (s_pixel > thr_r);
  assign cnt_sum_s   = sat_inc(cnt_r, white_acc_s);
  assign tot_sum_s   = sat_inc(tot_r, 1'b1);
  // Total only grows with or ahead of the white count, but both are checked for clarity.
  assign sat_sum_s   = sat_r | (tot_r == CNT_MAX) | (white_acc_s && (cnt_r == CNT_MAX));

  // Next-state and control decode for the frame FSM.
  always_comb begin
    state_nx_s  = state_r;
    start_s     = 1'b0;
    start_eof_s = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    release_s   = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (s_sof) begin
            start_s     = 1'b1;
            start_eof_s = s_eof;
            state_nx_s  = s_eof ? HOLD : ACCUM;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          if (s_sof) begin
            // Restart: the partial frame is dropped and this beat opens a new one.
            err_s       = 1'b1;
            start_s     = 1'b1;
            start_eof_s = s_eof;
            state_nx_s  = s_eof ? HOLD : ACCUM;
          end else begin
            step_s     = 1'b1;
            finish_s   = s_eof;
            state_nx_s = s_eof ? HOLD : ACCUM;
          end
        end else begin
          state_nx_s = ACCUM;
        end
      end
      HOLD: begin
        if (m_ready) begin
          release_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame accumulators, result registers and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_r       <= {PIX_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      tot_r       <= CNT_ZERO;
      sat_r       <= 1'b0;
      m_valid_r   <= 1'b0;
      m_count_r   <= CNT_ZERO;
      m_total_r   <= CNT_ZERO;
      m_sat_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= err_s;
      if (start_s) begin
        thr_r <= bin_threshold;
        cnt_r <= {{(CNT_W-1){1'b0}}, white_new_s};
        tot_r <= CNT_ONE;
        sat_r <= 1'b0;
      end else if (step_s) begin
        cnt_r <= cnt_sum_s;
        tot_r <= tot_sum_s;
        sat_r <= sat_sum_s;
      end else begin
        cnt_r <= cnt_r;
      end
      if (start_eof_s) begin
        m_valid_r <= 1'b1;
        m_count_r <= {{(CNT_W-1){1'b0}}, white_new_s};
        m_total_r <= CNT_ONE;
        m_sat_r   <= 1'b0;
      end else if (finish_s) begin
        m_valid_r <= 1'b1;
        m_count_r <= cnt_sum_s;
        m_total_r <= tot_sum_s;
        m_sat_r   <= sat_sum_s;
      end else if (release_s) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end
  end

  assign m_valid   = m_valid_r;
  assign m_count   = m_count_r;
  assign m_total   = m_total_r;
  assign m_sat     = m_sat_r;
  assign frame_err = frame_err_r;

endmodule

// File: doc/white_pixel_counter.md
# white_pixel_counter

Streaming binarize-and-count stage between the 3x3 Gaussian smoothing stage and the tumor threshold comparator. It accepts one smoothed pixel per beat over a valid/ready stream framed by start/end-of-frame markers. Each pixel is binarized against a per-frame threshold, and the block counts white pixels and total pixels. At end of frame it presents both counts on a held valid/ready result port; the white count drives the comparator's `white_pixel_count` input.

## Interface
- `PIX_W`, 8, pixel width (matches the smoothing stage's 8-bit output).
- `CNT_W`, 16, width of both counters and result fields (matches the comparator's 16-bit count input).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_pixel`  in  PIX_W  smoothed pixel value.
- `s_sof`  in  1  beat is the first pixel of a frame.
- `s_eof`  in  1  beat is the last pixel of a frame.
- `bin_threshold`  in  PIX_W  binarization threshold, sampled only on an accepted SOF beat.
- `m_valid`  out  1  frame result available.
- `m_ready`  in  1  downstream accepts result.
- `m_count`  out  CNT_W  white-pixel count of the last completed frame.
- `m_total`  out  CNT_W  total pixel count of the last completed frame.
- `m_sat`  out  1  either counter saturated during that frame.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- A beat is accepted when `s_valid && s_ready`; no other beat has any effect.
- A pixel is white iff `s_pixel > thr_q` (strict), where `thr_q` is `bin_threshold` latched on the SOF beat.
  - Changes to `bin_threshold` mid-frame are ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
  - A sticky `sat_q` flag is set when either counter would exceed the maximum; it is cleared on SOF.

FSM states: IDLE, ACCUM, HOLD.
- **IDLE**: `s_ready`=1.
  - SOF beat: latch threshold; `cnt` = white bit; `tot` = 1; `sat_q` = 0. Go to ACCUM, or to HOLD if `s_eof` is also set (single-pixel frame).
  - Non-SOF beat: dropped, `frame_err` pulses, state stays IDLE.
- **ACCUM**: `s_ready`=1.
  - Beat without SOF: `cnt` += white bit (saturating); `tot` += 1 (saturating).
  - Beat with `s_eof` (and no SOF): that pixel is included, the result registers are loaded, go to HOLD.
  - Beat with `s_sof`: `frame_err` pulses. The partial frame is discarded, and the beat is processed as an IDLE SOF beat, including the SOF+EOF case.
- **HOLD**: `s_ready`=0, `m_valid`=1.
  - `m_count`, `m_total` and `m_sat` are held stable.
  - On `m_ready` go to IDLE.
- `s_ready` is combinational from state and forced to 0 while `rst_n` is low.
- `m_*` outputs are registered.

## Timing
- Reset (sync, `rst_n` low at a clock edge): state IDLE, `m_valid`=0, `m_count`=0, `m_total`=0, `m_sat`=0, `frame_err`=0, counters 0. `s_ready` is 1 in the first cycle after reset deasserts.
- Reset mid-frame or in HOLD: the partial or pending result is discarded and `m_valid` drops at that edge.
- Latency: `m_valid` rises in the cycle after the EOF beat is accepted.
- Handshake completes on the cycle where `m_valid && m_ready`. `s_ready` returns to 1 in the next cycle, giving one bubble per frame.
- Frame throughput: one pixel per cycle while in IDLE/ACCUM.
- `frame_err` is asserted for exactly the cycle after the offending beat.
- `m_valid` never drops without a handshake or reset. `m_ready` is ignored while `m_valid`=0.

## Test plan
- **Basic count**: 16-pixel frame, threshold 100, pixels {0,50,100,101,200,255,99,150, then 8×10} → `m_count`=4, `m_total`=16, `m_sat`=0, `m_valid` 1 cycle after EOF. Pixel 100 must not be counted.
- **Backpressure**: hold `m_ready`=0 for 10 cycles after a result → `s_ready`=0 and result fields stable throughout. Then `m_ready`=1 for 1 cycle → `m_valid`=0 next cycle; a following SOF is accepted that cycle.
- **Single-pixel frame**: SOF+EOF with pixel 255, threshold 0 → `m_count`=1, `m_total`=1. Repeat with pixel 0 → `m_count`=0, `m_total`=1.
- **Framing errors**:
  - 3 beats without SOF in IDLE → 3 `frame_err` pulses, no result.
  - SOF mid-frame after 5 white beats, then 2 white beats with EOF on the last → `frame_err` pulse, `m_count`=3, `m_total`=3.
- **Saturation**: `CNT_W`=4, 20-beat all-white frame → `m_count`=15, `m_total`=15, `m_sat`=1. Next 2-pixel frame → `m_sat`=0.
- **Reset mid-frame**: `rst_n` low for 1 cycle after 7 beats, then a fresh 4-pixel frame with 2 white → `m_count`=2, `m_total`=4; no result is ever produced for the aborted frame.
